// File: rtl/down_count_monitor.sv
// Checker for a free-running down counter: tracks lock, wraps and step errors.
// Statistics saturate; clear wipes them without touching the tracking FSM.
module down_count_monitor #(
  parameter int WIDTH      = 4,
  parameter int RESYNC_LEN = 3,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     count,
  input  logic                 clear,
  output logic                 inSync,
  output logic                 wrap,
  output logic [CNT_WIDTH-1:0] wrapCount,
  output logic                 errorFlag,
  output logic [CNT_WIDTH-1:0] errorCount
);

  typedef enum logic [1:0] {
    ACQUIRE,
    RESYNC,
    TRACK
  } state_t;

  localparam logic [3:0] RLEN = 4'(RESYNC_LEN);

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     prev_q, prev_d;
  logic [3:0]           run_q, run_d;
  logic                 wrap_q, wrap_d;
  logic [CNT_WIDTH-1:0] wrap_cnt_q, wrap_cnt_d;
  logic                 err_flag_q, err_flag_d;
  logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

  logic [WIDTH-1:0] expected;
  logic             good;
  logic             wrap_ev;
  logic             err_ev;

  always_comb begin
    expected = prev_q - WIDTH'(1);
    good     = (count == expected);
    prev_d   = count;
    state_d  = state_q;
    run_d    = run_q;
    wrap_ev  = 1'b0;
    err_ev   = 1'b0;
    unique case (state_q)
      ACQUIRE: begin
        state_d = RESYNC;
        run_d   = '0;
      end
      RESYNC: begin
        if (good) begin
          run_d = run_q + 4'd1;
          if (run_q + 4'd1 == RLEN) begin
            state_d = TRACK;
            run_d   = '0;
          end
        end else begin
          run_d = '0;
        end
      end
      TRACK: begin
        if (good) begin
          wrap_ev = (prev_q == '0);
        end else begin
          err_ev  = 1'b1;
          state_d = RESYNC;
          run_d   = '0;
        end
      end
      default: begin
        state_d = ACQUIRE;
        run_d   = '0;
      end
    endcase
  end

  // Clear wins over same-cycle events; the wrap pulse itself is unaffected.
  always_comb begin
    wrap_d     = wrap_ev;
    wrap_cnt_d = wrap_cnt_q;
    err_flag_d = err_flag_q;
    err_cnt_d  = err_cnt_q;
    if (clear) begin
      wrap_cnt_d = '0;
      err_flag_d = 1'b0;
      err_cnt_d  = '0;
    end else begin
      if (wrap_ev && (wrap_cnt_q != '1))
        wrap_cnt_d = wrap_cnt_q + CNT_WIDTH'(1);
      if (err_ev) begin
        err_flag_d = 1'b1;
        if (err_cnt_q != '1)
          err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ACQUIRE;
      prev_q     <= '0;
      run_q      <= '0;
      wrap_q     <= 1'b0;
      wrap_cnt_q <= '0;
      err_flag_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      run_q      <= run_d;
      wrap_q     <= wrap_d;
      wrap_cnt_q <= wrap_cnt_d;
      err_flag_q <= err_flag_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign inSync     = (state_q == TRACK);
  assign wrap       = wrap_q;
  assign wrapCount  = wrap_cnt_q;
  assign errorFlag  = err_flag_q;
  assign errorCount = err_cnt_q;

endmodule

// File: tb/tb_down_count_monitor.sv
// Directed bench for down_count_monitor: vector table plus
// async reset and small-counter saturation sequences.
module tb_down_count_monitor;

  logic       clock;
  logic       reset;
  logic [3:0] count;
  logic       clear;
  logic       inSync;
  logic       wrap;
  logic [7:0] wrapCount;
  logic       errorFlag;
  logic [7:0] errorCount;

  logic       reset2;
  logic [3:0] count2;
  logic       clear2;
  logic       inSync2;
  logic       wrap2;
  logic [1:0] wrapCount2;
  logic       errorFlag2;
  logic [1:0] errorCount2;

  int n_checks = 0;
  int n_fail   = 0;

  down_count_monitor dut (
    .clock      (clock),
    .reset      (reset),
    .count      (count),
    .clear      (clear),
    .inSync     (inSync),
    .wrap       (wrap),
    .wrapCount  (wrapCount),
    .errorFlag  (errorFlag),
    .errorCount (errorCount)
  );

  down_count_monitor #(
    .WIDTH      (4),
    .RESYNC_LEN (1),
    .CNT_WIDTH  (2)
  ) dut2 (
    .clock      (clock),
    .reset      (reset2),
    .count      (count2),
    .clear      (clear2),
    .inSync     (inSync2),
    .wrap       (wrap2),
    .wrapCount  (wrapCount2),
    .errorFlag  (errorFlag2),
    .errorCount (errorCount2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] cnt;
    logic       clr;
    logic       sync;
    logic       wrp;
    logic [7:0] wc;
    logic       ef;
    logic [7:0] ec;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic [3:0] c, input logic cl,
                              input logic s, input logic w,
                              input logic [7:0] wc, input logic ef,
                              input logic [7:0] ec);
    vec_t v;
    v.cnt = c;  v.clr = cl; v.sync = s; v.wrp = w;
    v.wc = wc;  v.ef = ef;  v.ec = ec;
    vq.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic s, input logic w,
                         input logic [7:0] wc, input logic ef,
                         input logic [7:0] ec);
    chk({tag, "_sync"}, {31'b0, inSync}, {31'b0, s});
    chk({tag, "_wrap"}, {31'b0, wrap}, {31'b0, w});
    chk({tag, "_wc"}, {24'b0, wrapCount}, {24'b0, wc});
    chk({tag, "_ef"}, {31'b0, errorFlag}, {31'b0, ef});
    chk({tag, "_ec"}, {24'b0, errorCount}, {24'b0, ec});
  endtask

  task automatic apply(input logic [3:0] c, input logic cl);
    count = c;
    clear = cl;
    @(posedge clock);
    #1;
  endtask

  logic [3:0] s_cnt [12];
  logic       s_sync[12];
  logic [1:0] s_ec  [12];

  initial begin
    reset  = 1'b1;
    count  = '0;
    clear  = 1'b0;
    reset2 = 1'b1;
    count2 = '0;
    clear2 = 1'b0;

    // acquire
    add(15, 0, 0, 0, 0, 0, 0);
    add(14, 0, 0, 0, 0, 0, 0);
    add(13, 0, 0, 0, 0, 0, 0);
    add(12, 0, 1, 0, 0, 0, 0);
    for (int v = 11; v >= 0; v--) add(4'(v), 0, 1, 0, 0, 0, 0);
    // tracked wrap
    add(15, 0, 1, 1, 1, 0, 0);
    add(14, 0, 1, 0, 1, 0, 0);
    // glitch 9,8,3,2,1,0
    for (int v = 13; v >= 8; v--) add(4'(v), 0, 1, 0, 1, 0, 0);
    add(3, 0, 0, 0, 1, 1, 1);
    add(2, 0, 0, 0, 1, 1, 1);
    add(1, 0, 0, 0, 1, 1, 1);
    add(0, 0, 1, 0, 1, 1, 1);
    add(15, 0, 1, 1, 2, 1, 1);
    add(14, 0, 1, 0, 2, 1, 1);
    // wrap seen only while resyncing is not counted
    add(5, 0, 0, 0, 2, 1, 2);
    add(1, 0, 0, 0, 2, 1, 2);
    add(0, 0, 0, 0, 2, 1, 2);
    add(15, 0, 0, 0, 2, 1, 2);
    add(14, 0, 1, 0, 2, 1, 2);
    add(13, 0, 1, 0, 2, 1, 2);
    // clear together with a bad sample
    add(7, 1, 0, 0, 0, 0, 0);
    add(6, 0, 0, 0, 0, 0, 0);
    add(5, 0, 0, 0, 0, 0, 0);
    add(4, 0, 1, 0, 0, 0, 0);
    add(3, 0, 1, 0, 0, 0, 0);
    add(9, 0, 0, 0, 0, 1, 1);
    add(8, 0, 0, 0, 0, 1, 1);
    add(7, 0, 0, 0, 0, 1, 1);
    add(6, 0, 1, 0, 0, 1, 1);
    for (int v = 5; v >= 0; v--) add(4'(v), 0, 1, 0, 0, 1, 1);
    // clear with a wrap: pulse survives, count does not
    add(15, 1, 1, 1, 0, 0, 0);
    add(14, 0, 1, 0, 0, 0, 0);

    #1;
    chk_all("rst", 0, 0, 0, 0, 0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      apply(vq[i].cnt, vq[i].clr);
      chk_all($sformatf("v%0d", i), vq[i].sync, vq[i].wrp,
              vq[i].wc, vq[i].ef, vq[i].ec);
    end

    // get to TRACK with nonzero stats, then async reset
    apply(3, 0);
    chk_all("pre_err", 0, 0, 0, 1, 1);
    apply(2, 0);
    apply(1, 0);
    apply(0, 0);
    chk_all("pre_trk", 1, 0, 0, 1, 1);
    apply(15, 0);
    chk_all("pre_wrap", 1, 1, 1, 1, 1);
    reset = 1'b1;
    #1;
    chk_all("async_rst", 0, 0, 0, 0, 0);
    @(posedge clock);
    #1;
    chk_all("rst_hold", 0, 0, 0, 0, 0);
    @(negedge clock);
    reset = 1'b0;
    apply(15, 0);
    chk_all("re_e1", 0, 0, 0, 0, 0);
    apply(14, 0);
    chk_all("re_e2", 0, 0, 0, 0, 0);
    apply(13, 0);
    chk_all("re_e3", 0, 0, 0, 0, 0);
    apply(12, 0);
    chk_all("re_e4", 1, 0, 0, 0, 0);

    // saturation on the 2-bit statistics instance
    s_cnt  = '{5, 4, 4, 3, 3, 2, 2, 1, 1, 0, 0, 15};
    s_sync = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
    s_ec   = '{0, 0, 1, 1, 2, 2, 3, 3, 3, 3, 3, 3};
    @(negedge clock);
    reset2 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      count2 = s_cnt[i];
      @(posedge clock);
      #1;
      chk($sformatf("sat%0d_sync", i), {31'b0, inSync2},
          {31'b0, s_sync[i]});
      chk($sformatf("sat%0d_ec", i), {30'b0, errorCount2},
          {30'b0, s_ec[i]});
      chk($sformatf("sat%0d_wrap", i), {31'b0, wrap2}, 32'd0);
    end
    chk("sat_ef", {31'b0, errorFlag2}, 32'd1);
    chk("sat_wc", {30'b0, wrapCount2}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
